// File: rtl/circular_step_generator_pkg.sv
// Shared types for the circular step generator: step axis, FSM state and the
// position quadrant encoding.
package circular_step_generator_pkg;

    localparam int unsigned BYTE_BITS = 8;

    typedef enum logic {
        StepAxisX = 1'b0,
        StepAxisY = 1'b1
    } step_axis_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StEmit,
        StDone
    } circ_step_gen_state_e;

    typedef enum logic [1:0] {
        Quad1,
        Quad2,
        Quad3,
        Quad4
    } pos_quadrant_e;

endpackage

// File: rtl/circular_step_generator_if.sv
// Command and step-stream bundle for the circular step generator.
// CIRCULAR_STEP_GEN_END_CHECK_EN adds end_x/end_y and end_mismatch.
interface circular_step_generator_if #(
    parameter int unsigned NUM_BITS = circular_step_generator_pkg::BYTE_BITS
);
    localparam int unsigned STEP_BITS = NUM_BITS + 3;

    logic                        start;
    logic                        is_cw;
    logic signed [NUM_BITS-1:0]  start_x;
    logic signed [NUM_BITS-1:0]  start_y;
    logic        [NUM_BITS-1:0]  r;
    logic        [STEP_BITS-1:0] num_steps;
    logic                        busy;
    logic                        done;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_axis;
    logic                        out_neg;
    logic signed [NUM_BITS-1:0]  cur_x;
    logic signed [NUM_BITS-1:0]  cur_y;
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
    logic signed [NUM_BITS-1:0]  end_x;
    logic signed [NUM_BITS-1:0]  end_y;
    logic                        end_mismatch;

    modport master (
        output start, is_cw, start_x, start_y, r, num_steps, out_ready, end_x, end_y,
        input  busy, done, out_valid, out_axis, out_neg, cur_x, cur_y, end_mismatch
    );
    modport slave (
        input  start, is_cw, start_x, start_y, r, num_steps, out_ready, end_x, end_y,
        output busy, done, out_valid, out_axis, out_neg, cur_x, cur_y, end_mismatch
    );
`else
    modport master (
        output start, is_cw, start_x, start_y, r, num_steps, out_ready,
        input  busy, done, out_valid, out_axis, out_neg, cur_x, cur_y
    );
    modport slave (
        input  start, is_cw, start_x, start_y, r, num_steps, out_ready,
        output busy, done, out_valid, out_axis, out_neg, cur_x, cur_y
    );
`endif
endinterface

// File: rtl/circular_step_generator_chooser.sv
// Picks the next unit move along the arc: quadrant decode, both candidate
// error updates, and the smaller-|err| choice with ties going to X.
module circular_step_generator_chooser
    import circular_step_generator_pkg::*;
#(
    parameter int unsigned NUM_BITS = BYTE_BITS,
    localparam int unsigned ERR_BITS = 2 * NUM_BITS + 3
) (
    input  logic signed [NUM_BITS-1:0] cur_x,
    input  logic signed [NUM_BITS-1:0] cur_y,
    input  logic signed [ERR_BITS-1:0] err,
    input  logic                       is_cw,
    output step_axis_e                 axis,
    output logic                       neg,
    output logic signed [ERR_BITS-1:0] next_err
);
    pos_quadrant_e              quad;
    logic                       x_pos, x_neg, x_zero, y_pos, y_neg, y_zero;
    logic                       mx_neg, my_neg;
    logic signed [ERR_BITS-1:0] x_ext, y_ext, err_x, err_y;
    logic        [ERR_BITS-1:0] abs_x, abs_y;

    assign x_neg  = cur_x[NUM_BITS-1];
    assign y_neg  = cur_y[NUM_BITS-1];
    assign x_zero = (cur_x == '0);
    assign y_zero = (cur_y == '0);
    assign x_pos  = !x_neg && !x_zero;
    assign y_pos  = !y_neg && !y_zero;

    // (0,0) matches none of the four and falls through to Q1.
    always_comb begin
        quad = Quad1;
        if (x_pos && !y_neg) begin
            quad = Quad1;
        end else if (!x_pos && y_pos) begin
            quad = Quad2;
        end else if (x_neg && !y_pos) begin
            quad = Quad3;
        end else if (!x_neg && y_neg) begin
            quad = Quad4;
        end
    end

    always_comb begin
        mx_neg = 1'b0;
        my_neg = 1'b0;
        unique case (quad)
            Quad1: begin mx_neg = 1'b1; my_neg = 1'b0; end
            Quad2: begin mx_neg = 1'b1; my_neg = 1'b1; end
            Quad3: begin mx_neg = 1'b0; my_neg = 1'b1; end
            Quad4: begin mx_neg = 1'b0; my_neg = 1'b0; end
            default: ;
        endcase
        if (is_cw) begin
            mx_neg = !mx_neg;
            my_neg = !my_neg;
        end
    end

    assign x_ext = {{(ERR_BITS - NUM_BITS){cur_x[NUM_BITS-1]}}, cur_x};
    assign y_ext = {{(ERR_BITS - NUM_BITS){cur_y[NUM_BITS-1]}}, cur_y};

    // Moving c by s changes c^2 by 2*s*c + 1.
    assign err_x = mx_neg ? err - (x_ext <<< 1) + ERR_BITS'(1) : err + (x_ext <<< 1) + ERR_BITS'(1);
    assign err_y = my_neg ? err - (y_ext <<< 1) + ERR_BITS'(1) : err + (y_ext <<< 1) + ERR_BITS'(1);

    assign abs_x = err_x[ERR_BITS-1] ? -err_x : err_x;
    assign abs_y = err_y[ERR_BITS-1] ? -err_y : err_y;

    always_comb begin
        if (abs_y < abs_x) begin
            axis     = StepAxisY;
            neg      = my_neg;
            next_err = err_y;
        end else begin
            axis     = StepAxisX;
            neg      = mx_neg;
            next_err = err_x;
        end
    end

endmodule

// File: rtl/circular_step_generator.sv
// Walks a circular arc as unit X/Y moves, one per out handshake, for num_steps moves.
// Optional end-point check under CIRCULAR_STEP_GEN_END_CHECK_EN.
module circular_step_generator
    import circular_step_generator_pkg::*;
#(
    parameter int unsigned NUM_BITS = BYTE_BITS
) (
    input logic                      clk,
    input logic                      reset,
    circular_step_generator_if.slave bus
);
    localparam int unsigned STEP_BITS = NUM_BITS + 3;
    localparam int unsigned ERR_BITS  = 2 * NUM_BITS + 3;

    circ_step_gen_state_e       state_q;
    logic                       busy_q, done_q, out_valid_q, is_cw_q;
    logic signed [NUM_BITS-1:0] cur_x_q, cur_y_q;
    logic        [NUM_BITS-1:0] r_q;
    logic       [STEP_BITS-1:0] remaining_q;
    logic signed [ERR_BITS-1:0] err_q, load_err, next_err;
    logic signed [ERR_BITS-1:0] x_ext, y_ext, r_ext;
    step_axis_e                 axis;
    logic                       neg, handshake;
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
    logic signed [NUM_BITS-1:0] end_x_q, end_y_q;
    logic                       end_mismatch_q;
`endif

    circular_step_generator_chooser #(
        .NUM_BITS(NUM_BITS)
    ) u_chooser (
        .cur_x   (cur_x_q),
        .cur_y   (cur_y_q),
        .err     (err_q),
        .is_cw   (is_cw_q),
        .axis    (axis),
        .neg     (neg),
        .next_err(next_err)
    );

    assign x_ext    = {{(ERR_BITS - NUM_BITS){cur_x_q[NUM_BITS-1]}}, cur_x_q};
    assign y_ext    = {{(ERR_BITS - NUM_BITS){cur_y_q[NUM_BITS-1]}}, cur_y_q};
    assign r_ext    = {{(ERR_BITS - NUM_BITS){1'b0}}, r_q};
    assign load_err = x_ext * x_ext + y_ext * y_ext - r_ext * r_ext;
    assign handshake = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            is_cw_q     <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            r_q         <= '0;
            remaining_q <= '0;
            err_q       <= '0;
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
            end_x_q        <= '0;
            end_y_q        <= '0;
            end_mismatch_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        is_cw_q     <= bus.is_cw;
                        cur_x_q     <= bus.start_x;
                        cur_y_q     <= bus.start_y;
                        r_q         <= bus.r;
                        remaining_q <= bus.num_steps;
                        busy_q      <= 1'b1;
                        state_q     <= StLoad;
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
                        end_x_q        <= bus.end_x;
                        end_y_q        <= bus.end_y;
                        end_mismatch_q <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    err_q <= load_err;
                    if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        out_valid_q <= 1'b1;
                        state_q     <= StEmit;
                    end
                end
                StEmit: begin
                    if (handshake) begin
                        if (axis == StepAxisX) begin
                            cur_x_q <= neg ? cur_x_q - NUM_BITS'(1) : cur_x_q + NUM_BITS'(1);
                        end else begin
                            cur_y_q <= neg ? cur_y_q - NUM_BITS'(1) : cur_y_q + NUM_BITS'(1);
                        end
                        err_q       <= next_err;
                        remaining_q <= remaining_q - STEP_BITS'(1);
                        if (remaining_q == STEP_BITS'(1)) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
                    end_mismatch_q <= (cur_x_q != end_x_q) | (cur_y_q != end_y_q);
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    // Gated so the idle outputs read 0 rather than the chooser's idle pick.
    assign bus.out_axis  = out_valid_q & (axis == StepAxisY);
    assign bus.out_neg   = out_valid_q & neg;
    assign bus.cur_x     = cur_x_q;
    assign bus.cur_y     = cur_y_q;
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
    assign bus.end_mismatch = end_mismatch_q;
`endif

endmodule

// File: tb/tb_circular_step_generator.sv
// Scoreboard bench for circular_step_generator: a point model predicts every
// move at command time; each handshake pops and compares against it.
module tb_circular_step_generator;
    localparam int unsigned NumBits  = 8;
    localparam int unsigned StepBits = NumBits + 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    circular_step_generator_if #(.NUM_BITS(NumBits)) bus ();

    circular_step_generator #(
        .NUM_BITS(NumBits)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int axis;
        int neg;
        int x;
        int y;
    } step_t;

    step_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    last_x, last_y;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int sq_err(input int x, input int y, input int r);
        return x * x + y * y - r * r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step(input int x, input int y, input int r, input bit cw,
                              output int axis, output int neg);
        int sx, sy;
        if (x > 0 && y >= 0)      begin sx = -1; sy =  1; end
        else if (x <= 0 && y > 0) begin sx = -1; sy = -1; end
        else if (x < 0 && y <= 0) begin sx =  1; sy = -1; end
        else if (x >= 0 && y < 0) begin sx =  1; sy =  1; end
        else                      begin sx = -1; sy =  1; end
        if (cw) begin sx = -sx; sy = -sy; end
        if (iabs(sq_err(x, y + sy, r)) < iabs(sq_err(x + sx, y, r))) begin
            axis = 1; neg = (sy < 0) ? 1 : 0;
        end else begin
            axis = 0; neg = (sx < 0) ? 1 : 0;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " busy"},      int'(bus.busy), 0);
        check({name, " done"},      int'(bus.done), 0);
        check({name, " out_valid"}, int'(bus.out_valid), 0);
        check({name, " out_axis"},  int'(bus.out_axis), 0);
        check({name, " out_neg"},   int'(bus.out_neg), 0);
        check({name, " cur_x"},     int'($signed(bus.cur_x)), 0);
        check({name, " cur_y"},     int'($signed(bus.cur_y)), 0);
    endtask

    task automatic run_cmd(input string name, input bit cw, input int sx, input int sy,
                           input int r, input int n, input int stall_at, input int stall_len,
                           input bit rand_ready, input int abort_after, input bit err_bound);
        int x, y, ax, ng, fx, fy, t, hs, stall_cnt, first_valid, done_t, last_hs, busy_cnt;
        bit prev_stall;
        step_t e;
        x = sx;
        y = sy;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            model_step(x, y, r, cw, ax, ng);
            exp_q.push_back('{ax, ng, x, y});
            if (ax == 0) x += (ng != 0) ? -1 : 1;
            else         y += (ng != 0) ? -1 : 1;
        end
        fx = x;
        fy = y;

        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_cw     = cw;
        bus.start_x   = NumBits'(sx);
        bus.start_y   = NumBits'(sy);
        bus.r         = NumBits'(r);
        bus.num_steps = StepBits'(n);
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
        bus.end_x     = NumBits'(fx);
        bus.end_y     = NumBits'(fy);
`endif
        t = 0; hs = 0; stall_cnt = 0; first_valid = -1; done_t = -1; last_hs = -1;
        busy_cnt = 0; prev_stall = 1'b0;
        while (done_t < 0 && t < 8 * n + 40) begin
            @(negedge clk);
            t++;
            bus.start = 1'b0;
            if (abort_after >= 0 && hs == abort_after) begin
                reset = 1'b0;
                #1;
                check_idle_outputs({name, " abort"});
                exp_q.delete();
                repeat (3) begin
                    @(negedge clk);
                    check({name, " abort no done"}, int'(bus.done), 0);
                end
                reset = 1'b1;
                return;
            end
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            else bus.out_ready = !(hs == stall_at && stall_cnt < stall_len);
            if (bus.busy) busy_cnt++;
            if (prev_stall) check({name, " valid held"}, int'(bus.out_valid), 1);
            if (bus.out_valid) begin
                if (first_valid < 0) first_valid = t;
                if (exp_q.size() == 0) begin
                    check({name, " unexpected step"}, 1, 0);
                end else begin
                    e = exp_q[0];
                    check({name, " axis"},  int'(bus.out_axis), e.axis);
                    check({name, " neg"},   int'(bus.out_neg), e.neg);
                    check({name, " cur_x"}, int'($signed(bus.cur_x)), e.x);
                    check({name, " cur_y"}, int'($signed(bus.cur_y)), e.y);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        hs++;
                        last_hs = t;
                        if (err_bound) begin
                            ax = sq_err(int'($signed(bus.cur_x)), int'($signed(bus.cur_y)), r);
                            check({name, " err in range"}, int'(ax >= -3 && ax <= 1), 1);
                        end
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            if (bus.done) done_t = t;
        end
        bus.out_ready = 1'b1;
        check({name, " done seen"}, int'(done_t >= 0), 1);
        if (n > 0) begin
            check({name, " first valid"}, first_valid, 2);
            check({name, " done after last"}, done_t, last_hs + 1);
        end else begin
            check({name, " never valid"}, first_valid, -1);
            check({name, " done time"}, done_t, 2);
        end
        check({name, " handshakes"}, hs, n);
        check({name, " busy cycles"}, busy_cnt, done_t);
        check({name, " final x"}, int'($signed(bus.cur_x)), fx);
        check({name, " final y"}, int'($signed(bus.cur_y)), fy);
        last_x = int'($signed(bus.cur_x));
        last_y = int'($signed(bus.cur_y));
        @(negedge clk);
        check({name, " done pulse"}, int'(bus.done), 0);
        check({name, " busy drop"}, int'(bus.busy), 0);
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
        check({name, " end_mismatch"}, int'(bus.end_mismatch), 0);
`endif
    endtask

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.is_cw     = 1'b0;
        bus.start_x   = '0;
        bus.start_y   = '0;
        bus.r         = '0;
        bus.num_steps = '0;
        bus.out_ready = 1'b1;
`ifdef CIRCULAR_STEP_GEN_END_CHECK_EN
        bus.end_x     = '0;
        bus.end_y     = '0;
`endif
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;

        run_cmd("ccw4", 1'b0, 2, 0, 2, 4, -1, 0, 1'b0, -1, 1'b1);
        check("ccw4 end x", last_x, 0);
        check("ccw4 end y", last_y, 2);
        run_cmd("cw4", 1'b1, 2, 0, 2, 4, -1, 0, 1'b0, -1, 1'b1);
        check("cw4 end x", last_x, 0);
        check("cw4 end y", last_y, -2);
        run_cmd("ccw16", 1'b0, 2, 0, 2, 16, -1, 0, 1'b0, -1, 1'b1);
        check("ccw16 home x", last_x, 2);
        check("ccw16 home y", last_y, 0);
        run_cmd("zero", 1'b0, 2, 0, 2, 0, -1, 0, 1'b0, -1, 1'b0);
        run_cmd("stall", 1'b0, 2, 0, 2, 4, 1, 5, 1'b0, -1, 1'b1);
        run_cmd("abort", 1'b0, 2, 0, 2, 4, -1, 0, 1'b0, 2, 1'b0);
        run_cmd("after abort", 1'b0, 2, 0, 2, 4, -1, 0, 1'b0, -1, 1'b1);
        run_cmd("r5 ccw", 1'b0, 5, 0, 5, 40, -1, 0, 1'b0, -1, 1'b0);
        check("r5 home x", last_x, 5);
        check("r5 home y", last_y, 0);
        run_cmd("r3 cw rand", 1'b1, 0, -3, 3, 12, -1, 0, 1'b1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
